stream_packet_splitter: RTL and testbench
=========================================

Name: stream_packet_splitter

Overview:
- Parametrised successor of the fixed image/audio splitter.
- Sits between the RMII-style 2-bit receive path and the frame-buffer writer / audio FIFO.
- Assembles dibits into bytes, then splits each packet (delimited by axiiv) into a multi-byte address header, a counted pixel payload and a counted audio payload.
- Adds per-field indices, packet-complete/error reporting and resynchronisation after reset.

Parameters:
ADDR_BYTES, 3, number of header address bytes (>=1).
PIXEL_BYTES, 320, pixel bytes per packet (>=1).
AUDIO_BYTES, 64, audio bytes per packet (>=1).
PIX_IDX_W, $clog2(PIXEL_BYTES), width of pixel_idx (derived, do not override).
AUD_IDX_W, $clog2(AUDIO_BYTES), width of audio_idx (derived, do not override).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
axiiv  in  1  dibit valid; high for the whole packet, low between packets
axiid  in  2  dibit data
addr_axiov  out  1  one-cycle pulse, addr valid
addr  out  8*ADDR_BYTES  packet address
pixel_axiov  out  1  one-cycle pulse per pixel byte
pixel  out  8  pixel byte
pixel_idx  out  PIX_IDX_W  index of current pixel byte, 0..PIXEL_BYTES-1
audio_axiov  out  1  one-cycle pulse per audio byte
audio  out  8  audio byte
audio_idx  out  AUD_IDX_W  index of current audio byte
pkt_done  out  1  one-cycle pulse, packet ended with exact length
pkt_err  out  1  one-cycle pulse, packet ended malformed
err_code  out  2  valid with pkt_err: 2'b01 short/misaligned, 2'b10 long

Behaviour:
- Reset is asynchronous and active-high. All outputs and counters go to 0 and state goes to SYNC.
- Byte assembly: 4 dibits per byte, LSB first. The first dibit lands in bits [1:0] and the fourth in [7:6]. The dibit counter advances only on cycles with axiiv=1.
- Address bytes arrive MSB byte first. Byte k (0-based) lands in addr[8*(ADDR_BYTES-k)-1 -: 8].
- Byte-done latency: the *_axiov pulse, its data and its index are registered. They appear on the clock edge after the edge that samples the 4th dibit. Data and index hold until the next byte of that field.
- States:
  - SYNC: after reset, ignore input until one cycle with axiiv=0 is seen, then go to IDLE. This prevents locking on mid-packet.
  - IDLE: on axiiv=1, consume that dibit as dibit 0 of address byte 0, go to ADDR.
  - ADDR: after byte ADDR_BYTES-1 completes, pulse addr_axiov (full addr) and go to PIXELS.
  - PIXELS: each completed byte pulses pixel_axiov, with pixel_idx = 0,1,... After index PIXEL_BYTES-1, go to AUDIO.
  - AUDIO: same as PIXELS using audio_axiov/audio_idx. After index AUDIO_BYTES-1, go to TAIL.
  - TAIL: any further dibit with axiiv=1 sets an internal long flag. No further *_axiov pulses.
- End of packet: the first cycle with axiiv=0 while in ADDR/PIXELS/AUDIO/TAIL. On the following edge:
  - TAIL, long flag clear, dibit counter 0: pkt_done=1.
  - TAIL, long flag set: pkt_err=1, err_code=2'b10.
  - Any other state, or dibit counter non-zero: pkt_err=1, err_code=2'b01.
  - In all cases go to IDLE and clear the counters and long flag.
- pkt_done and pkt_err are never high together. err_code holds its value until the next pkt_err.
- Bytes already emitted from a short packet are not retracted. Downstream uses pkt_err to discard.
- addr_axiov, pixel_axiov and audio_axiov are mutually exclusive in any cycle.
- Reset mid-packet: outputs clear immediately. The remainder of that packet is ignored (SYNC).
- Index arithmetic is unsigned, no wrap. Counters never exceed their field size, because the state changes at the last byte.

Decomposition:
- Shared package splitter_pkg:
  - state enum {SYNC, IDLE, ADDR, PIXELS, AUDIO, TAIL}, logic [2:0] typed.
  - err_code localparams ERR_SHORT=2'b01, ERR_LONG=2'b10.
- One sub-module, dibit_byte_assembler (clk, rst, axiiv, axiid, clr -> byte_valid, byte_data). It holds the 2-bit dibit counter and shift register; clr is driven at end of packet.

Test Plan:
Benches use ADDR_BYTES=3, PIXEL_BYTES=4, AUDIO_BYTES=2.
- Exact packet: addr 0x12_34_56, pixels A5,00,FF,3C, audio 81,7E, then axiiv=0. Expect:
  - addr_axiov once with addr=24'h123456.
  - 4 pixel pulses with idx 0..3 and the matching bytes.
  - 2 audio pulses.
  - pkt_done one cycle after axiiv falls; pkt_err=0.
- Dibit order: byte 0xA5 sent as dibits 01,01,10,10 -> pixel=8'hA5, emitted one cycle after the 4th dibit.
- Short packet: axiiv drops after pixel idx 1 -> no audio pulses; pkt_err=1, err_code=2'b01. The next packet is accepted normally.
- Long packet: 8 extra dibits after the last audio byte -> no extra pulses; pkt_err=1, err_code=2'b10.
- Misaligned end: exact length plus 2 dibits -> pkt_err, err_code=2'b01 or 2'b10 per the rule above (counter non-zero means 2'b01).
- Reset while axiiv=1 mid-pixels: outputs 0 immediately; no pulses until axiiv goes low. The following full packet yields pkt_done.

Source files
------------

// File: rtl/splitter_pkg.sv
// ============================================================================
// Package : splitter_pkg
// Purpose : Shared types and constants for stream_packet_splitter.
//           - state_t   : packet parser states
//           - ERR_*     : err_code encodings reported with pkt_err
//           - idx_width : index width helper, never narrower than 1 bit
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package splitter_pkg;

  typedef enum logic [2:0] {
    SYNC   = 3'd0,
    IDLE   = 3'd1,
    ADDR   = 3'd2,
    PIXELS = 3'd3,
    AUDIO  = 3'd4,
    TAIL   = 3'd5
  } state_t;

  localparam logic [1:0] ERR_SHORT = 2'b01;
  localparam logic [1:0] ERR_LONG  = 2'b10;

  // A field of a single byte still needs a 1-bit index signal.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/dibit_byte_assembler.sv
// ============================================================================
// Module  : dibit_byte_assembler
// Purpose : Collects four 2-bit dibits (LSB first) into a byte.
// Ports   : clk, rst        - clock, asynchronous active-high reset
//           axiiv, axiid    - dibit valid / dibit data
//           clr             - synchronous clear of the dibit counter
//           byte_valid      - combinational: 4th dibit is on axiid this cycle
//           byte_data       - combinational: assembled byte (valid with byte_valid)
//           mid_byte        - dibit counter is non-zero (partial byte held)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module dibit_byte_assembler (
  input  logic       clk,
  input  logic       rst,
  input  logic       axiiv,
  input  logic [1:0] axiid,
  input  logic       clr,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       mid_byte
);

  logic [1:0] cnt_q;
  // Holds the first three dibits; the oldest drifts down to [1:0].
  logic [5:0] sh_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= 2'd0;
      sh_q  <= 6'd0;
    end else if (clr) begin
      cnt_q <= 2'd0;
    end else if (axiiv) begin
      cnt_q <= cnt_q + 2'd1;
      sh_q  <= {axiid, sh_q[5:2]};
    end
  end

  assign byte_valid = axiiv && !clr && (cnt_q == 2'd3);
  assign byte_data  = {axiid, sh_q};
  assign mid_byte   = (cnt_q != 2'd0);

endmodule

`default_nettype wire

// File: rtl/stream_packet_splitter.sv
// ============================================================================
// Module  : stream_packet_splitter
// Purpose : Splits a dibit packet stream into an address header, a counted
//           pixel payload and a counted audio payload, with end-of-packet
//           length checking.
// Ports   : clk, rst                 - clock, asynchronous active-high reset
//           axiiv, axiid             - dibit valid (frames packet) / data
//           addr_axiov, addr         - address pulse / full header address
//           pixel_axiov, pixel,
//           pixel_idx                - pixel byte pulse / data / index
//           audio_axiov, audio,
//           audio_idx                - audio byte pulse / data / index
//           pkt_done                 - packet ended with exact length
//           pkt_err, err_code        - packet malformed / reason (held)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module stream_packet_splitter
  import splitter_pkg::*;
#(
  parameter int ADDR_BYTES  = 3,
  parameter int PIXEL_BYTES = 320,
  parameter int AUDIO_BYTES = 64,
  parameter int PIX_IDX_W   = idx_width(PIXEL_BYTES),
  parameter int AUD_IDX_W   = idx_width(AUDIO_BYTES)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    axiiv,
  input  logic [1:0]              axiid,
  output logic                    addr_axiov,
  output logic [8*ADDR_BYTES-1:0] addr,
  output logic                    pixel_axiov,
  output logic [7:0]              pixel,
  output logic [PIX_IDX_W-1:0]    pixel_idx,
  output logic                    audio_axiov,
  output logic [7:0]              audio,
  output logic [AUD_IDX_W-1:0]    audio_idx,
  output logic                    pkt_done,
  output logic                    pkt_err,
  output logic [1:0]              err_code
);

  localparam int ADDR_W     = 8 * ADDR_BYTES;
  localparam int ADDR_CNT_W = idx_width(ADDR_BYTES);

  localparam logic [ADDR_CNT_W-1:0] ADDR_LAST = ADDR_CNT_W'(ADDR_BYTES - 1);
  localparam logic [PIX_IDX_W-1:0]  PIX_LAST  = PIX_IDX_W'(PIXEL_BYTES - 1);
  localparam logic [AUD_IDX_W-1:0]  AUD_LAST  = AUD_IDX_W'(AUDIO_BYTES - 1);

  state_t                  state_q;
  logic [ADDR_CNT_W-1:0]   addr_cnt_q;
  logic [PIX_IDX_W-1:0]    pix_cnt_q;
  logic [AUD_IDX_W-1:0]    aud_cnt_q;
  logic                    long_q;
  logic [ADDR_W-1:0]       addr_acc_q;
  logic [ADDR_W-1:0]       addr_acc_d;

  logic                    byte_valid;
  logic [7:0]              byte_data;
  logic                    mid_byte;
  logic                    asm_clr;

  // Between packets and while resynchronising the assembler is held empty,
  // so the first dibit of every accepted packet is dibit 0 of a byte.
  assign asm_clr = (state_q == SYNC) || !axiiv;

  dibit_byte_assembler u_asm (
    .clk        (clk),
    .rst        (rst),
    .axiiv      (axiiv),
    .axiid      (axiid),
    .clr        (asm_clr),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .mid_byte   (mid_byte)
  );

  // Address bytes arrive MSB first: shift left and append; after ADDR_BYTES
  // bytes the first one sits in the top byte lane.
  assign addr_acc_d = ADDR_W'({addr_acc_q, byte_data});

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= SYNC;
      addr_cnt_q  <= '0;
      pix_cnt_q   <= '0;
      aud_cnt_q   <= '0;
      long_q      <= 1'b0;
      addr_acc_q  <= '0;
      addr_axiov  <= 1'b0;
      addr        <= '0;
      pixel_axiov <= 1'b0;
      pixel       <= '0;
      pixel_idx   <= '0;
      audio_axiov <= 1'b0;
      audio       <= '0;
      audio_idx   <= '0;
      pkt_done    <= 1'b0;
      pkt_err     <= 1'b0;
      err_code    <= '0;
    end else begin
      addr_axiov  <= 1'b0;
      pixel_axiov <= 1'b0;
      audio_axiov <= 1'b0;
      pkt_done    <= 1'b0;
      pkt_err     <= 1'b0;

      case (state_q)
        SYNC: begin
          // Wait for an inter-packet gap before trusting the stream.
          if (!axiiv) state_q <= IDLE;
        end

        IDLE: begin
          if (axiiv) state_q <= ADDR;
        end

        default: begin
          if (!axiiv) begin
            // End of packet: only a fully aligned stop in TAIL is clean.
            if (state_q == TAIL && !mid_byte) begin
              if (long_q) begin
                pkt_err  <= 1'b1;
                err_code <= ERR_LONG;
              end else begin
                pkt_done <= 1'b1;
              end
            end else begin
              pkt_err  <= 1'b1;
              err_code <= ERR_SHORT;
            end
            state_q    <= IDLE;
            addr_cnt_q <= '0;
            pix_cnt_q  <= '0;
            aud_cnt_q  <= '0;
            long_q     <= 1'b0;
          end else if (state_q == TAIL) begin
            long_q <= 1'b1;
          end else if (byte_valid) begin
            case (state_q)
              ADDR: begin
                addr_acc_q <= addr_acc_d;
                if (addr_cnt_q == ADDR_LAST) begin
                  addr       <= addr_acc_d;
                  addr_axiov <= 1'b1;
                  addr_cnt_q <= '0;
                  state_q    <= PIXELS;
                end else begin
                  addr_cnt_q <= addr_cnt_q + 1'b1;
                end
              end

              PIXELS: begin
                pixel       <= byte_data;
                pixel_idx   <= pix_cnt_q;
                pixel_axiov <= 1'b1;
                if (pix_cnt_q == PIX_LAST) begin
                  pix_cnt_q <= '0;
                  state_q   <= AUDIO;
                end else begin
                  pix_cnt_q <= pix_cnt_q + 1'b1;
                end
              end

              AUDIO: begin
                audio       <= byte_data;
                audio_idx   <= aud_cnt_q;
                audio_axiov <= 1'b1;
                if (aud_cnt_q == AUD_LAST) begin
                  aud_cnt_q <= '0;
                  state_q   <= TAIL;
                end else begin
                  aud_cnt_q <= aud_cnt_q + 1'b1;
                end
              end

              default: begin
              end
            endcase
          end
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_stream_packet_splitter.sv
// ============================================================================
// Module  : tb_stream_packet_splitter
// Purpose : Directed packets against stream_packet_splitter
//           (ADDR_BYTES=3, PIXEL_BYTES=4, AUDIO_BYTES=2) with a queue of
//           expected output events consumed by an independent monitor.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_stream_packet_splitter;

  localparam int AB = 3;
  localparam int PB = 4;
  localparam int UB = 2;

  localparam int K_ADDR = 0;
  localparam int K_PIX  = 1;
  localparam int K_AUD  = 2;
  localparam int K_DONE = 3;
  localparam int K_ERR  = 4;

  logic        clk   = 1'b0;
  logic        rst   = 1'b1;
  logic        axiiv = 1'b0;
  logic [1:0]  axiid = 2'b00;

  logic        addr_axiov;
  logic [23:0] addr;
  logic        pixel_axiov;
  logic [7:0]  pixel;
  logic [1:0]  pixel_idx;
  logic        audio_axiov;
  logic [7:0]  audio;
  logic [0:0]  audio_idx;
  logic        pkt_done;
  logic        pkt_err;
  logic [1:0]  err_code;

  stream_packet_splitter #(
    .ADDR_BYTES  (AB),
    .PIXEL_BYTES (PB),
    .AUDIO_BYTES (UB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .axiiv       (axiiv),
    .axiid       (axiid),
    .addr_axiov  (addr_axiov),
    .addr        (addr),
    .pixel_axiov (pixel_axiov),
    .pixel       (pixel),
    .pixel_idx   (pixel_idx),
    .audio_axiov (audio_axiov),
    .audio       (audio),
    .audio_idx   (audio_idx),
    .pkt_done    (pkt_done),
    .pkt_err     (pkt_err),
    .err_code    (err_code)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          kind;
    logic [23:0] data;
    int          idx;
    logic [1:0]  ec;
    int          cyc;
  } ev_t;

  ev_t exq[$];
  int  cyc     = 0;
  int  drv_cyc = 0;
  int  errors  = 0;
  int  checks  = 0;

  // ---------------------------------------------------------------- monitor
  task automatic check_ev(input int kind, input logic [23:0] data,
                          input int idx, input logic [1:0] ec);
    ev_t e;
    checks++;
    if (exq.size() == 0) begin
      errors++;
      $display("FAIL unexpected_event: got kind=%0d data=%h idx=%0d ec=%b at cyc=%0d, expected none",
               kind, data, idx, ec, cyc);
    end else begin
      e = exq.pop_front();
      if (e.kind != kind || e.data != data || e.idx != idx || e.ec != ec || e.cyc != cyc) begin
        errors++;
        $display("FAIL event: got kind=%0d data=%h idx=%0d ec=%b cyc=%0d, expected kind=%0d data=%h idx=%0d ec=%b cyc=%0d",
                 kind, data, idx, ec, cyc, e.kind, e.data, e.idx, e.ec, e.cyc);
      end
    end
  endtask

  always @(posedge clk) begin
    int n;
    cyc++;
    #1;
    n = int'(addr_axiov) + int'(pixel_axiov) + int'(audio_axiov) + int'(pkt_done) + int'(pkt_err);
    if (n > 0) begin
      checks++;
      if (n > 1) begin
        errors++;
        $display("FAIL exclusive_pulses: got %0d simultaneous pulses at cyc=%0d, expected 1", n, cyc);
      end
    end
    if (addr_axiov)  check_ev(K_ADDR, addr, 0, 2'b00);
    if (pixel_axiov) check_ev(K_PIX, {16'h0, pixel}, int'(pixel_idx), 2'b00);
    if (audio_axiov) check_ev(K_AUD, {16'h0, audio}, int'(audio_idx), 2'b00);
    if (pkt_done)    check_ev(K_DONE, 24'h0, 0, err_code);
    if (pkt_err)     check_ev(K_ERR, 24'h0, 0, err_code);
  end

  // ---------------------------------------------------------------- drivers
  task automatic push(input int kind, input logic [23:0] data,
                      input int idx, input logic [1:0] ec);
    ev_t e;
    e.kind = kind;
    e.data = data;
    e.idx  = idx;
    e.ec   = ec;
    e.cyc  = drv_cyc + 1;   // one register stage after the sampling edge
    exq.push_back(e);
  endtask

  task automatic send_dibit(input logic [1:0] d);
    @(negedge clk);
    axiiv   = 1'b1;
    axiid   = d;
    drv_cyc = cyc;
  endtask

  task automatic send_byte(input logic [7:0] b);
    for (int i = 0; i < 4; i++) send_dibit(b[2*i +: 2]);
  endtask

  task automatic end_pkt();
    @(negedge clk);
    axiiv   = 1'b0;
    axiid   = 2'b00;
    drv_cyc = cyc;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      axiiv = 1'b0;
    end
  endtask

  // pix: first byte in the MSB lane; aud likewise.
  task automatic send_pkt(input logic [23:0] a, input logic [31:0] pix,
                          input logic [15:0] aud, input int npix, input int naud,
                          input int extra, input int exp_kind, input logic [1:0] exp_ec);
    logic [7:0] b;
    for (int k = 0; k < AB; k++) begin
      b = a[8*(AB-1-k) +: 8];
      send_byte(b);
    end
    push(K_ADDR, a, 0, 2'b00);
    for (int i = 0; i < npix; i++) begin
      b = pix[8*(PB-1-i) +: 8];
      send_byte(b);
      push(K_PIX, {16'h0, b}, i, 2'b00);
    end
    for (int i = 0; i < naud; i++) begin
      b = aud[8*(UB-1-i) +: 8];
      send_byte(b);
      push(K_AUD, {16'h0, b}, i, 2'b00);
    end
    for (int i = 0; i < extra; i++) send_dibit(2'(i));
    end_pkt();
    push(exp_kind, 24'h0, 0, exp_ec);
    idle(2);
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [7:0] b;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    checks++;
    if ({addr_axiov, pixel_axiov, audio_axiov, pkt_done, pkt_err} != 5'b0 ||
        addr != 24'h0 || pixel != 8'h0 || pixel_idx != 2'd0 ||
        audio != 8'h0 || audio_idx != 1'b0 || err_code != 2'b00) begin
      errors++;
      $display("FAIL reset_state: got addr=%h pixel=%h pidx=%0d audio=%h aidx=%0d ec=%b, expected all zero",
               addr, pixel, pixel_idx, audio, audio_idx, err_code);
    end
    rst = 1'b0;
    idle(3);

    // Exact packet; first pixel A5 exercises dibit order 01,01,10,10
    send_pkt(24'h123456, 32'hA500FF3C, 16'h817E, 4, 2, 0, K_DONE, 2'b00);
    // Short packet: stops after pixel index 1
    send_pkt(24'hAABBCC, 32'h11220000, 16'h0000, 2, 0, 0, K_ERR, 2'b01);
    // Next packet accepted normally; err_code still holds 01
    send_pkt(24'h000001, 32'h5AC30FF0, 16'h00FF, 4, 2, 0, K_DONE, 2'b01);
    // Long packet: 8 aligned extra dibits
    send_pkt(24'hFEDCBA, 32'h01020304, 16'h8001, 4, 2, 8, K_ERR, 2'b10);
    // Misaligned: 2 extra dibits leave a partial byte
    send_pkt(24'h0F0F0F, 32'hDEADBEEF, 16'h55AA, 4, 2, 2, K_ERR, 2'b01);

    // Reset in the middle of the pixel field
    for (int k = 0; k < AB; k++) begin
      b = 8'h70 + 8'(k);
      send_byte(b);
    end
    push(K_ADDR, 24'h707172, 0, 2'b00);
    send_byte(8'h9C);
    push(K_PIX, 24'h00009C, 0, 2'b00);
    send_byte(8'h63);
    push(K_PIX, 24'h000063, 1, 2'b00);
    send_dibit(2'b11);
    send_dibit(2'b10);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({addr_axiov, pixel_axiov, audio_axiov, pkt_done, pkt_err} != 5'b0 ||
        addr != 24'h0 || pixel != 8'h0 || pixel_idx != 2'd0 || err_code != 2'b00) begin
      errors++;
      $display("FAIL midreset_outputs: got addr=%h pixel=%h pidx=%0d ec=%b, expected all zero",
               addr, pixel, pixel_idx, err_code);
    end
    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL midreset_pending: got %0d outstanding events, expected 0", exq.size());
      exq.delete();
    end
    @(negedge clk);
    rst = 1'b0;
    // Rest of the interrupted packet must be ignored
    for (int i = 0; i < 10; i++) send_dibit(2'(i * 3));
    end_pkt();
    idle(2);
    // Following full packet completes cleanly; err_code was reset to 00
    send_pkt(24'h123456, 32'hA500FF3C, 16'h817E, 4, 2, 0, K_DONE, 2'b00);

    // Drain with a bounded wait
    for (int i = 0; i < 50 && exq.size() > 0; i++) @(negedge clk);
    checks++;
    if (exq.size() != 0) begin
      errors++;
      $display("FAIL drain_timeout: got %0d events never seen, expected 0", exq.size());
    end
    idle(3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

`default_nettype wire
